// File: rtl/multiplicador_uc.sv
// Shift-and-add multiplier sequencer: INIT, then WIDTH x (TEST[,ADD],SHIFT), then a DONE pulse.
// Latency: DONE is entered 1 + 2*WIDTH + popcount(Q) edges after start is sampled; start is ignored while busy.
module multiplicador_uc (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       qlsb,
    input  logic       zero,
    output logic       busy,
    output logic       done,
    output logic       a_rst,
    output logic       a_ld,
    output logic       a_en,
    output logic       b_ld,
    output logic       b_en,
    output logic       q_ld,
    output logic       q_en,
    output logic       cnt_ld,
    output logic       cnt_en,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        INIT  = 3'd1,
        TEST  = 3'd2,
        ADD   = 3'd3,
        SHIFT = 3'd4,
        DONE  = 3'd5
    } state_t;

    logic [2:0] state;
    logic [2:0] nxt;

    always_comb begin
        nxt = IDLE;
        case (state)
            IDLE:    nxt = start ? INIT : IDLE;
            INIT:    nxt = TEST;
            TEST:    nxt = qlsb ? ADD : SHIFT;
            ADD:     nxt = SHIFT;
            SHIFT:   nxt = zero ? DONE : TEST;
            default: nxt = IDLE; // DONE and the unused codes 6/7
        endcase
    end

    // Outputs are registered alongside the state, decoded from the state being entered.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            a_rst  <= 1'b1;
            a_ld   <= 1'b0;
            a_en   <= 1'b0;
            b_ld   <= 1'b0;
            q_ld   <= 1'b0;
            q_en   <= 1'b0;
            cnt_ld <= 1'b0;
            cnt_en <= 1'b0;
        end else begin
            state  <= nxt;
            busy   <= (nxt != IDLE);
            done   <= (nxt == DONE);
            a_rst  <= (nxt != INIT);
            a_ld   <= (nxt == ADD);
            a_en   <= (nxt == SHIFT);
            b_ld   <= (nxt == INIT);
            q_ld   <= (nxt == INIT);
            q_en   <= (nxt == SHIFT);
            cnt_ld <= (nxt == INIT);
            cnt_en <= (nxt == SHIFT);
        end
    end

    // B is loaded once per operation and never shifted.
    assign b_en    = 1'b0;
    assign state_o = state;

endmodule
